// File: rtl/instr_issue_queue.sv
// Instruction issue queue: a small FIFO between the instruction loader and the
// pipeline. The head entry is held back with a bubble while it reads a register
// written by one of the last HAZ_WINDOW issued instructions.
module instr_issue_queue #(
    parameter int DEPTH      = 4,
    parameter int HAZ_WINDOW = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            in_instr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   hold,
    input  logic                   flush,
    output logic [31:0]            InstrOut,
    output logic                   WriteEnable,
    output logic                   bubble,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Outcome of the issue-side decision for the current edge.
    typedef enum logic [1:0] {
        ISS_IDLE,
        ISS_BUBBLE,
        ISS_POP
    } issue_e;

    // FIFO storage and pointers
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Issue history: destinations of the most recent issue slots, [0] newest
    logic          r_hist_vld [HAZ_WINDOW];
    logic [4:0]    r_hist_dst [HAZ_WINDOW];

    // Registered pipeline outputs
    logic [31:0]   r_instr_out;
    logic          r_we;
    logic          r_bubble;

    // Head decode and control
    logic [31:0]   w_head;
    logic          w_is_r;
    logic          w_is_i;
    logic          w_use_rs;
    logic          w_use_rt;
    logic          w_dst_vld;
    logic          w_hazard;
    issue_e        w_issue;
    logic          w_advance;
    logic          w_push;
    logic          w_pop;

    assign in_ready    = (r_count < FULL);
    assign count       = r_count;
    assign InstrOut    = r_instr_out;
    assign WriteEnable = r_we;
    assign bubble      = r_bubble;

    // Decode the head entry and compare its sources against the issue history.
    always_comb begin
        w_head    = r_mem[r_rd_ptr];
        w_is_r    = (w_head[31:29] == 3'b010);
        w_is_i    = (w_head[31:29] == 3'b011);
        w_use_rs  = w_is_r | w_is_i;
        // The unary "not" carries an rt field that it never reads.
        w_use_rt  = w_is_r && (w_head[31:26] != 6'b010001);
        w_dst_vld = w_is_r | w_is_i;
        w_hazard  = 1'b0;
        for (int unsigned i = 0; i < HAZ_WINDOW; i++) begin
            if (r_hist_vld[i] &&
                ((w_use_rs && (r_hist_dst[i] == w_head[20:16])) ||
                 (w_use_rt && (r_hist_dst[i] == w_head[15:11])))) begin
                w_hazard = 1'b1;
            end
        end
    end

    // Choose idle, bubble or pop for the head; empty is judged on registered count.
    always_comb begin
        w_issue = ISS_IDLE;
        if (r_count == '0) begin
            w_issue = ISS_IDLE;
        end else if (w_hazard) begin
            w_issue = ISS_BUBBLE;
        end else begin
            w_issue = ISS_POP;
        end
    end

    assign w_advance = !hold && !flush;
    assign w_pop     = w_advance && (w_issue == ISS_POP);
    assign w_push    = in_valid && in_ready && !flush;

    // FIFO pointer and occupancy bookkeeping; flush empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_instr;
        end
    end

    // Registered issue outputs; frozen while the pipeline holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr_out <= '0;
            r_we        <= 1'b0;
            r_bubble    <= 1'b0;
        end else if (flush) begin
            r_instr_out <= '0;
            r_we        <= 1'b0;
            r_bubble    <= 1'b0;
        end else if (!hold) begin
            case (w_issue)
                ISS_POP: begin
                    r_instr_out <= w_head;
                    r_we        <= 1'b1;
                    r_bubble    <= 1'b0;
                end
                ISS_BUBBLE: begin
                    r_instr_out <= '0;
                    r_we        <= 1'b0;
                    r_bubble    <= 1'b1;
                end
                default: begin
                    r_instr_out <= '0;
                    r_we        <= 1'b0;
                    r_bubble    <= 1'b0;
                end
            endcase
        end
    end

    // Issue history shift: only a popped writing instruction enters as valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < HAZ_WINDOW; i++) begin
                r_hist_vld[i] <= 1'b0;
                r_hist_dst[i] <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < HAZ_WINDOW; i++) begin
                r_hist_vld[i] <= 1'b0;
                r_hist_dst[i] <= '0;
            end
        end else if (!hold) begin
            for (int unsigned i = HAZ_WINDOW - 1; i > 0; i--) begin
                r_hist_vld[i] <= r_hist_vld[i-1];
                r_hist_dst[i] <= r_hist_dst[i-1];
            end
            r_hist_vld[0] <= w_pop && w_dst_vld;
            r_hist_dst[0] <= w_head[25:21];
        end
    end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Bench for instr_issue_queue: directed scenarios followed by randomized
// traffic, every edge compared against a queue-based reference model.
module tb_instr_issue_queue;

    localparam int DEPTH = 4;
    localparam int HAZ   = 2;

    logic                   clk;
    logic                   rst;
    logic [31:0]            in_instr;
    logic                   in_valid;
    logic                   in_ready;
    logic                   hold;
    logic                   flush;
    logic [31:0]            InstrOut;
    logic                   WriteEnable;
    logic                   bubble;
    logic [$clog2(DEPTH):0] count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m_q[$];
    int          m_hist[$];
    logic [31:0] m_out;
    logic        m_we;
    logic        m_bub;

    instr_issue_queue #(
        .DEPTH      (DEPTH),
        .HAZ_WINDOW (HAZ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_instr    (in_instr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .hold        (hold),
        .flush       (flush),
        .InstrOut    (InstrOut),
        .WriteEnable (WriteEnable),
        .bubble      (bubble),
        .count       (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int dest_of(input logic [31:0] w);
        if (w[31:29] == 3'b010 || w[31:29] == 3'b011) return int'(w[25:21]);
        return -1;
    endfunction

    function automatic bit reads_pending(input logic [31:0] w);
        int srcs[$];
        if (w[31:29] == 3'b010 || w[31:29] == 3'b011) srcs.push_back(int'(w[20:16]));
        if (w[31:29] == 3'b010 && w[31:26] != 6'b010001) srcs.push_back(int'(w[15:11]));
        foreach (m_hist[i]) begin
            foreach (srcs[j]) begin
                if (m_hist[i] >= 0 && m_hist[i] == srcs[j]) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_hist.delete();
        repeat (HAZ) m_hist.push_back(-1);
        m_out = '0;
        m_we  = 1'b0;
        m_bub = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [31:0] d, input logic hd, input logic fl);
        bit accept;
        int dst;
        if (fl) begin
            model_reset();
            return;
        end
        accept = v && (m_q.size() < DEPTH);
        if (!hd) begin
            dst = -1;
            if (m_q.size() == 0) begin
                m_out = '0; m_we = 1'b0; m_bub = 1'b0;
            end else if (reads_pending(m_q[0])) begin
                m_out = '0; m_we = 1'b0; m_bub = 1'b1;
            end else begin
                m_out = m_q[0]; m_we = 1'b1; m_bub = 1'b0;
                dst = dest_of(m_q[0]);
                void'(m_q.pop_front());
            end
            m_hist.push_front(dst);
            void'(m_hist.pop_back());
        end
        if (accept) m_q.push_back(d);
    endtask

    // One clock: drive inputs, check in_ready, step model at the edge, compare after it.
    task automatic cycle(input logic v, input logic [31:0] d, input logic hd, input logic fl);
        in_valid = v;
        in_instr = d;
        hold     = hd;
        flush    = fl;
        check("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
        @(posedge clk);
        model_edge(v, d, hd, fl);
        #1;
        check("InstrOut", InstrOut, m_out);
        check("WriteEnable", 32'(WriteEnable), 32'(m_we));
        check("bubble", 32'(bubble), 32'(m_bub));
        check("count", 32'(count), 32'(m_q.size()));
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        case ($urandom_range(0, 3))
            0:       op = {3'b010, 3'($urandom_range(0, 7))};
            1:       op = 6'b010001;
            2:       op = {3'b011, 3'($urandom_range(0, 7))};
            default: op = 6'($urandom_range(0, 63));
        endcase
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 11'($urandom)};
    endfunction

    initial begin
        rst      = 1'b1;
        in_instr = '0;
        in_valid = 1'b0;
        hold     = 1'b0;
        flush    = 1'b0;
        model_reset();

        // Reset state, including across a clock edge while held
        #2 rst = 1'b0;
        #5;
        check("rst_instr", InstrOut, 32'h0);
        check("rst_we", 32'(WriteEnable), 32'h0);
        check("rst_bubble", 32'(bubble), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);
        #5 rst = 1'b1;

        // Single push issues one edge later
        cycle(1'b1, 32'h68000005, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("lat_instr", InstrOut, 32'h68000005);
        check("lat_we", 32'(WriteEnable), 32'h1);
        check("lat_count", 32'(count), 32'h0);
        idle(3);

        // RAW on r1: two bubbles before the consumer issues
        cycle(1'b1, 32'h6821000A, 1'b0, 1'b0);
        cycle(1'b1, 32'h49011000, 1'b0, 1'b0);
        check("raw_first", InstrOut, 32'h6821000A);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("raw_b1_instr", InstrOut, 32'h0);
        check("raw_b1_bubble", 32'(bubble), 32'h1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("raw_b2_bubble", 32'(bubble), 32'h1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("raw_second", InstrOut, 32'h49011000);
        check("raw_second_bubble", 32'(bubble), 32'h0);
        idle(3);

        // Hold while pushing five: only four fit, then they drain in order
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 32'(i), 1'b1, 1'b0);
            if (i == 4) check("full_ready", 32'(in_ready), 32'h0);
        end
        check("full_count", 32'(count), 32'h4);
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            check("drain_order", InstrOut, 32'(i));
        end
        idle(3);

        // Producer writes r10; unary not names r10 in rt but reads only rs=r1
        cycle(1'b1, 32'h69400000, 1'b0, 1'b0);
        cycle(1'b1, 32'h44E15000, 1'b0, 1'b0);
        check("not_first", InstrOut, 32'h69400000);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("not_b2b", InstrOut, 32'h44E15000);
        check("not_nobubble", 32'(bubble), 32'h0);
        idle(3);

        // Flush with three queued, then normal issue resumes
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
        cycle(1'b1, 32'h1FF, 1'b0, 1'b1);
        check("flush_count", 32'(count), 32'h0);
        check("flush_we", 32'(WriteEnable), 32'h0);
        cycle(1'b1, 32'h68000005, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("post_flush_issue", InstrOut, 32'h68000005);
        idle(3);

        // Asynchronous reset between edges with two entries queued
        cycle(1'b1, 32'h11, 1'b1, 1'b0);
        cycle(1'b1, 32'h12, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'h0);
        check("arst_we", 32'(WriteEnable), 32'h0);
        check("arst_instr", InstrOut, 32'h0);
        check("arst_ready", 32'(in_ready), 32'h1);
        model_reset();
        #3 rst = 1'b1;
        idle(3);
        cycle(1'b1, 32'h68000005, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("post_arst_issue", InstrOut, 32'h68000005);
        idle(3);

        // Randomized traffic: light then heavy hold pressure
        for (int i = 0; i < 600; i++) begin
            int hold_pct;
            hold_pct = (i < 300) ? 20 : 55;
            cycle(1'b1 && ($urandom_range(0, 99) < 65), rand_instr(),
                  ($urandom_range(0, 99) < hold_pct), ($urandom_range(0, 59) == 0));
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
